// File: rtl/xgriscv_fetch_queue_pkg.sv
// Shared core constants for the fetch front end: default widths and the
// canonical NOP (addi x0, x0, 0) presented when the queue is empty.
package xgriscv_fetch_queue_pkg;
  localparam int ADDR_SIZE  = 32;
  localparam int INSTR_SIZE = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
endpackage

// File: rtl/xg_sync_fifo.sv
// Generic in-order synchronous FIFO with flush; reused by fetch and store paths.
module xg_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/xgriscv_fetch_queue.sv
// Fetch PC generation plus a DEPTH-entry {pc, instr} queue feeding decode.
module xgriscv_fetch_queue
  import xgriscv_fetch_queue_pkg::*;
#(
  parameter int ADDR_W  = ADDR_SIZE,
  parameter int INSTR_W = INSTR_SIZE,
  parameter int DEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   count
);
  logic [ADDR_W-1:0]         pc;
  logic [ADDR_W+INSTR_W-1:0] head;
  logic                      full, empty, enq;
  logic                      unused_rpc_lsb;

  assign unused_rpc_lsb = ^redirect_pc[1:0];
  assign imem_addr      = pc;
  assign enq            = fetch_en & ~full & ~redirect;

  always_ff @(posedge clk) begin
    if (reset)         pc <= RESET_PC;
    else if (redirect) pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
    else if (enq)      pc <= pc + ADDR_W'(4);
  end

  xg_sync_fifo #(.WIDTH(ADDR_W + INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (enq),
    .pop   (out_ready),
    .flush (redirect),
    .din   ({pc, imem_rdata}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Stale storage must never leak out; empty presents a clean bubble.
  assign out_valid = ~empty;
  assign out_pc    = empty ? '0 : head[ADDR_W+INSTR_W-1:INSTR_W];
  assign out_instr = empty ? INSTR_W'(INSTR_NOP) : head[INSTR_W-1:0];
endmodule

// File: tb/tb_xgriscv_fetch_queue.sv
// Bench: directed vector table with fixed expectations plus a queue scoreboard
// that tracks every fetched {pc, instr} until decode consumes it.
module tb_xgriscv_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] TAG = 32'hC0DE_0000;

  logic        clk = 0, reset = 0, fetch_en = 0, redirect = 0, out_ready = 0;
  logic [31:0] redirect_pc = 0, imem_addr, imem_rdata, out_pc, out_instr;
  logic        out_valid;
  logic [2:0]  count;

  int checks = 0, errors = 0;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        sb[$];
  logic [31:0] mpc;

  typedef struct {
    logic rst, fe, rdy, rd; logic [31:0] rpc;
    int e_cnt; logic [31:0] e_addr; logic e_vld; logic [31:0] e_pc;
  } vec_t;
  vec_t vecs[$];

  assign imem_rdata = imem_addr ^ TAG;

  always #5 clk = ~clk;

  xgriscv_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .count(count)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of stimulus, advances the scoreboard, then checks outputs.
  task automatic step(logic rst, logic fe, logic rdy, logic rd, logic [31:0] rpc);
    logic do_enq;
    reset = rst; fetch_en = fe; out_ready = rdy; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    if (rst) begin
      sb.delete(); mpc = RESET_PC;
    end else if (rd) begin
      sb.delete(); mpc = {rpc[31:2], 2'b00};
    end else begin
      do_enq = fe && (sb.size() < DEPTH);
      if (rdy && sb.size() > 0) void'(sb.pop_front());
      if (do_enq) begin
        sb.push_back('{pc: mpc, instr: mpc ^ TAG});
        mpc = mpc + 32'd4;
      end
    end
    @(negedge clk);
    chk("imem_addr", imem_addr, mpc);
    chk("count", {29'd0, count}, sb.size());
    chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
    chk("out_pc", out_pc, sb.size() != 0 ? sb[0].pc : 32'h0);
    chk("out_instr", out_instr, sb.size() != 0 ? sb[0].instr : NOP);
  endtask

  function automatic void add(logic rst, logic fe, logic rdy, logic rd, logic [31:0] rpc,
                              int e_cnt, logic [31:0] e_addr, logic e_vld, logic [31:0] e_pc);
    vecs.push_back('{rst, fe, rdy, rd, rpc, e_cnt, e_addr, e_vld, e_pc});
  endfunction

  initial begin
    mpc = RESET_PC;
    // Streaming from reset: one instruction per cycle, occupancy 1.
    add(1,0,0,0,0,            0, 32'h0,  0, 32'h0);
    add(0,1,1,0,0,            1, 32'h4,  1, 32'h0);
    add(0,1,1,0,0,            1, 32'h8,  1, 32'h4);
    add(0,1,1,0,0,            1, 32'hC,  1, 32'h8);
    add(0,1,1,0,0,            1, 32'h10, 1, 32'hC);
    // Decode stalled for 10 cycles: saturate at DEPTH, PC holds at 0x10.
    add(1,0,0,0,0,            0, 32'h0,  0, 32'h0);
    add(0,1,0,0,0,            1, 32'h4,  1, 32'h0);
    add(0,1,0,0,0,            2, 32'h8,  1, 32'h0);
    add(0,1,0,0,0,            3, 32'hC,  1, 32'h0);
    for (int i = 0; i < 7; i++) add(0,1,0,0,0, 4, 32'h10, 1, 32'h0);
    // Release while full: dequeue without enqueue, then resume.
    add(0,1,1,0,0,            3, 32'h10, 1, 32'h4);
    add(0,1,1,0,0,            3, 32'h14, 1, 32'h8);
    add(0,1,1,0,0,            3, 32'h18, 1, 32'hC);
    add(0,1,1,0,0,            3, 32'h1C, 1, 32'h10);
    // Redirect with 3 entries held; misaligned target is forced to word.
    add(0,1,0,1,32'h103,      0, 32'h100, 0, 32'h0);
    add(0,1,0,0,0,            1, 32'h104, 1, 32'h100);
    add(0,1,0,0,0,            2, 32'h108, 1, 32'h100);
    // Reset beats a simultaneous redirect.
    add(1,1,1,1,32'h200,      0, 32'h0,  0, 32'h0);
    // PC wraps past the top of the address space.
    add(0,1,0,1,32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 32'h0);
    add(0,1,0,0,0,            1, 32'h0,  1, 32'hFFFF_FFFC);
    add(0,1,1,0,0,            1, 32'h4,  1, 32'h0);
    // Fetch disabled: PC holds, drain continues.
    add(0,0,1,0,0,            0, 32'h4,  0, 32'h0);
    add(0,0,0,0,0,            0, 32'h4,  0, 32'h0);

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].fe, vecs[i].rdy, vecs[i].rd, vecs[i].rpc);
      chk($sformatf("vec%0d.count", i), {29'd0, count}, vecs[i].e_cnt);
      chk($sformatf("vec%0d.addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d.valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_vld});
      chk($sformatf("vec%0d.pc", i), out_pc, vecs[i].e_pc);
    end

    // Hold stability under stall across a few cycles with a full queue.
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
    begin
      logic [31:0] hp, hi;
      hp = out_pc; hi = out_instr;
      for (int i = 0; i < 3; i++) begin
        step(0, 1, 0, 0, 0);
        chk("stall_pc_stable", out_pc, hp);
        chk("stall_instr_stable", out_instr, hi);
      end
    end

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      logic rst, rd;
      rst = ($urandom_range(0, 99) == 0);
      rd  = ($urandom_range(0, 19) == 0);
      step(rst, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rd, $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/xgriscv_fetch_queue.md
# xgriscv_fetch_queue

Parametrised instruction-fetch front end for the pipelined xgriscv core. It generates the fetch PC, reads a combinational instruction memory, and buffers up to DEPTH {pc, instr} pairs in an in-order queue. The decode stage drains the queue through a valid/ready handshake. This decouples fetch from decode stalls and flushes the queue on branch/jump redirects. It sits between `imem` and the decode stage of the core datapath, replacing the direct `pcF`/`instr` wiring.

## Interface
- `ADDR_W`, 32, width of PC and instruction address
- `INSTR_W`, 32, instruction width
- `DEPTH`, 4, queue entries; power of two, ≥2
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `fetch_en`  in  1  permit new fetches (0 = hold PC, no enqueue)
- `redirect`  in  1  flush queue and restart fetch at `redirect_pc`
- `redirect_pc`  in  ADDR_W  redirect target
- `imem_addr`  out  ADDR_W  address to instruction memory (= current fetch PC)
- `imem_rdata`  in  INSTR_W  instruction at `imem_addr`, same cycle (combinational memory)
- `out_valid`  out  1  queue head valid
- `out_ready`  in  1  decode accepts head this cycle
- `out_pc`  out  ADDR_W  PC of head entry
- `out_instr`  out  INSTR_W  instruction of head entry
- `count`  out  $clog2(DEPTH)+1  current occupancy

## Operation
- State: fetch PC register `pc`, DEPTH-entry storage, read pointer, write pointer, occupancy counter.
- `imem_addr = pc` continuously.
- enq = `fetch_en & ~full & ~redirect`. On enq: write {pc, imem_rdata} at the write pointer, advance the write pointer, and set pc <= pc + 4 (mod 2^ADDR_W; wraps 0xFFFF_FFFC → 0).
- deq = `out_valid & out_ready`. On deq: advance the read pointer.
- Pointers are log2(DEPTH) bits and wrap naturally. full = (count == DEPTH). empty = (count == 0).
- count: +1 on enq only, −1 on deq only, unchanged on both or neither.
- Full blocks enqueue even if deq occurs the same cycle. There is no combinational path from `out_ready` to enqueue.
- Empty: `out_valid = 0`, `out_pc = 0`, `out_instr = 32'h0000_0013` (NOP). There is no bypass from `imem_rdata` to the output.
- Redirect, which has priority over everything except reset:
  - count <= 0 and both pointers <= 0.
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - No enqueue in that cycle.
  - A deq in the redirect cycle is a completed handshake, but it has no further effect.
- `fetch_en = 0`: pc holds and no enqueue occurs. Dequeue continues normally.

## Timing
- Reset, synchronous, highest priority:
  - pc = RESET_PC, so `imem_addr = RESET_PC` in the cycle after reset is sampled.
  - count = 0, pointers = 0, `out_valid = 0`, `out_pc = 0`, `out_instr = NOP`.
- Reset asserted mid-operation discards all entries and any pending redirect on the next edge.
- Fetch-to-visible latency is 1 cycle: an entry enqueued at edge N is presented on `out_*` after edge N, if it is at the head.
- Redirect latency:
  - `redirect` sampled at edge N → `out_valid = 0` after edge N.
  - `imem_addr = redirect_pc` after edge N.
  - The first target instruction is valid after edge N+1.
- Steady state with `out_ready = 1` and `fetch_en = 1`: one instruction per cycle, occupancy stays at 1.
- Handshake: `out_pc`/`out_instr` must stay stable while `out_valid = 1` and `out_ready = 0`. `out_valid` deasserts without a handshake only on redirect or reset.

## Structure
- The NOP encoding and `INSTR_SIZE`/`ADDR_SIZE` constants belong in the shared `xgriscv_defines.v`. Default `ADDR_W`/`INSTR_W` come from them.
- Storage and pointers go in one generic sub-module, `xg_sync_fifo` (params `WIDTH`, `DEPTH`; ports push, pop, flush, din, dout, full, empty, count). Give it the same synchronous reset.
- `xgriscv_fetch_queue` holds the PC register, enqueue/redirect logic, and the empty-output muxing. `xg_sync_fifo` is reusable for a later store buffer.

## Test plan
- Reset release, `fetch_en = 1`, `out_ready = 1`, imem returns addr-tagged words → `out_pc` sequence 0, 4, 8, 12 from cycle 1, one per cycle, `count` stays 1.
- `out_ready = 0` for 10 cycles (DEPTH = 4):
  - `count` saturates at 4 and `imem_addr` holds at 0x10.
  - `out_pc` holds at 0x0.
  - After `out_ready = 1`, output is 0, 4, 8, 12, 16 with no gaps or duplicates.
- Queue holds 3 entries, `redirect = 1`, `redirect_pc = 0x0000_0103`:
  - Next cycle: `out_valid = 0`, `count = 0`, `imem_addr = 0x100`.
  - Following cycle: `out_pc = 0x100`.
- Full queue with `out_ready = 1` → `count` goes 4 → 3 and no enqueue that cycle. Next cycle, enqueue resumes.
- Redirect and reset asserted in the same cycle → reset wins, `imem_addr = RESET_PC`.
- PC wrap: `redirect_pc = 0xFFFF_FFFC` → entries 0xFFFF_FFFC then 0x0000_0000.
